// File: rtl/keypad_pkg.sv
// Shared keypad sweep definitions: FSM states, one-hot row encodings, one-hot decode helper.
// Pure types/constants, no latency, no flow control.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Bit 3 is row0 / col0 on both the row drive and the column lines.
    localparam logic [3:0] ROW0 = 4'b1000;
    localparam logic [3:0] ROW1 = 4'b0100;
    localparam logic [3:0] ROW2 = 4'b0010;
    localparam logic [3:0] ROW3 = 4'b0001;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } onehot_idx_t;

    function automatic onehot_idx_t onehot4_to_idx(input logic [3:0] v);
        onehot_idx_t r;
        r.vld = 1'b1;
        r.idx = 2'd0;
        case (v)
            ROW0:    r.idx = 2'd0;
            ROW1:    r.idx = 2'd1;
            ROW2:    r.idx = 2'd2;
            ROW3:    r.idx = 2'd3;
            default: r.vld = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/keypad_col_decoder_if.sv
// Decoder-side keypad bundle: row drive and raw columns in, hold and key report out.
// Wires only, no latency; hold is the only flow-control signal (pauses the row sweeper).
interface keypad_col_decoder_if;
    logic [3:0] row_sel;
    logic [3:0] col_n;
    logic       hold;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        output row_sel, col_n,
        input  hold, key_code, key_valid, key_down
    );

    modport slave (
        input  row_sel, col_n,
        output hold, key_code, key_valid, key_down
    );
endinterface

// File: rtl/keypad_col_decoder_sync2.sv
// Two-flop synchronizer with parameterised reset value for asynchronous inputs.
// Latency 2 cycles; no flow control.
module sync2 #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_col_decoder.sv
// Debounces one keypad press against the swept row; latency 2 + DEBOUNCE_CYCLES for press and release.
// No backpressure on outputs; hold pauses the upstream sweeper while a key is qualified or held.
module keypad_col_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keypad_col_decoder_if.slave  kp
);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       col_s;
    onehot_idx_t      row_dec;
    onehot_idx_t      col_dec;
    logic             hit;
    logic             row_same;
    logic             col_same;

    kp_state_t        state,     state_nxt;
    logic [CNT_W-1:0] cnt,       cnt_nxt;
    logic [1:0]       cap_row,   cap_row_nxt;
    logic [3:0]       cap_col,   cap_col_nxt;
    logic [3:0]       key_code_q, key_code_nxt;
    logic             key_valid_q, key_valid_nxt;
    logic             key_down_q,  key_down_nxt;

    sync2 #(.W(4), .RST_VAL(4'b1111)) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp.col_n),
        .q     (col_s)
    );

    // Active-low columns: a single pressed column is a one-hot pattern once inverted.
    // Ghosts (several low bits) and all-high both decode as invalid.
    assign row_dec  = onehot4_to_idx(kp.row_sel);
    assign col_dec  = onehot4_to_idx(~col_s);
    assign hit      = row_dec.vld & col_dec.vld;
    assign row_same = row_dec.vld && (row_dec.idx == cap_row);
    assign col_same = (col_s == cap_col);

    // Raised in IDLE on the same cycle the row is captured so the sweeper cannot step past it.
    assign kp.hold      = (state != IDLE) | hit;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= CNT_ZERO;
            cap_row     <= 2'd0;
            cap_col     <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cap_row     <= cap_row_nxt;
            cap_col     <= cap_col_nxt;
            key_code_q  <= key_code_nxt;
            key_valid_q <= key_valid_nxt;
            key_down_q  <= key_down_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cap_row_nxt   = cap_row;
        cap_col_nxt   = cap_col;
        key_code_nxt  = key_code_q;
        key_valid_nxt = 1'b0;
        key_down_nxt  = key_down_q;

        case (state)
            IDLE: begin
                if (hit) begin
                    cap_row_nxt = row_dec.idx;
                    cap_col_nxt = col_s;
                    cnt_nxt     = CNT_ONE;
                    state_nxt   = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (row_same && col_same) begin
                    // The capture sample counts as the first stable one.
                    if (cnt >= CNT_LAST) begin
                        state_nxt     = PRESSED;
                        key_code_nxt  = {cap_row, col_dec.idx};
                        key_valid_nxt = 1'b1;
                        key_down_nxt  = 1'b1;
                        cnt_nxt       = CNT_ZERO;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = CNT_ZERO;
                end
            end

            PRESSED: begin
                if (col_same) begin
                    cnt_nxt = CNT_ZERO;
                end else begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                if (col_same) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt    = IDLE;
                    key_down_nxt = 1'b0;
                    cnt_nxt      = CNT_ZERO;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end
endmodule
